// File: rtl/sgd_host_wr_arbiter.sv
// Round-robin arbiter sharing the host-memory write channel between NUM_REQ producers.
// Define SGD_WR_ARB_STATS_EN to add per-requester transfer counters and a sticky error flag.
module sgd_host_wr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 512,
    parameter int LEN_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_start,
    input  logic [NUM_REQ*64-1:0]     req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_length,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_data_valid,
    output logic [NUM_REQ-1:0]        req_almost_full,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic                      out_start,
    output logic [63:0]               out_addr,
    output logic [LEN_W-1:0]          out_length,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_data_valid,
    input  logic                      out_almost_full,
    output logic [2:0]                grant_id
`ifdef SGD_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     stat_xfers,
    output logic                      stat_err
`endif
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = LEN_W - 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [63:0]       addr_q [NUM_REQ];
    logic [LEN_W-1:0]  len_q  [NUM_REQ];
    logic [DATA_W-1:0] odata_q;
    logic              ovalid_q;

    logic [NUM_REQ-1:0] granted;
    logic [NUM_REQ-1:0] capture;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic [63:0]       sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic              win_found;
    logic [IDX_W-1:0]  win;
    logic [LEN_W-1:0]  win_len;
    logic              beat_acc;
    logic              last_beat;

    always_comb begin
        granted   = '0;
        capture   = '0;
        req_busy  = '0;
        req_almost_full = '1;
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_addr  = '0;
        sel_len   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            granted[i]  = (state_q != S_IDLE) && (grant_q == IDX_W'(i));
            req_busy[i] = pending_q[i] | granted[i];
            capture[i]  = req_start[i] && (req_length[i*LEN_W +: LEN_W] != '0) && !req_busy[i];
            if (state_q == S_DATA && grant_q == IDX_W'(i)) begin
                req_almost_full[i] = out_almost_full;
            end
            if (grant_q == IDX_W'(i)) begin
                sel_valid = req_data_valid[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
                sel_addr  = addr_q[i];
                sel_len   = len_q[i];
            end
        end
    end

    // Round robin: first pending index above last, then wrap to the lowest index at or below it.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        win_len   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && pending_q[i] && IDX_W'(i) > last_q) begin
                win_found = 1'b1;
                win       = IDX_W'(i);
                win_len   = len_q[i];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && pending_q[i] && IDX_W'(i) <= last_q) begin
                win_found = 1'b1;
                win       = IDX_W'(i);
                win_len   = len_q[i];
            end
        end
    end

    assign beat_acc  = (state_q == S_DATA) && sel_valid;
    assign last_beat = beat_acc && (beats_q <= BEAT_W'(1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        beats_d   = beats_q;
        pending_d = pending_q | capture;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win;
                    beats_d = win_len[LEN_W-1:6];
                    pending_d[win] = 1'b0;
                    state_d = S_CMD;
                end
            end
            S_CMD: state_d = S_DATA;
            S_DATA: begin
                if (last_beat) begin
                    beats_d = '0;
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else if (beat_acc) begin
                    beats_d = beats_q - BEAT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            beats_q   <= '0;
            pending_q <= '0;
            odata_q   <= '0;
            ovalid_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                addr_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            beats_q   <= beats_d;
            pending_q <= pending_d;
            odata_q   <= beat_acc ? sel_data : '0;
            ovalid_q  <= beat_acc;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (capture[i]) begin
                    addr_q[i] <= req_addr[i*64 +: 64];
                    len_q[i]  <= req_length[i*LEN_W +: LEN_W];
                end
            end
        end
    end

    assign out_start      = (state_q == S_CMD);
    assign out_addr       = out_start ? sel_addr : '0;
    assign out_length     = out_start ? sel_len : '0;
    assign out_data       = odata_q;
    assign out_data_valid = ovalid_q;
    assign grant_id       = 3'(grant_q);

`ifdef SGD_WR_ARB_STATS_EN
    logic [31:0]  xfer_q [NUM_REQ];
    logic         err_q;
    logic         err_ev;

    assign err_ev = |(req_start & req_busy) | |(req_data_valid & ~granted);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                xfer_q[i] <= '0;
            end
        end else begin
            if (err_ev) begin
                err_q <= 1'b1;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (last_beat && grant_q == IDX_W'(i)) begin
                    xfer_q[i] <= xfer_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stat_xfers = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            stat_xfers[i*32 +: 32] = xfer_q[i];
        end
    end
    assign stat_err = err_q;
`endif

endmodule

// File: tb/tb_sgd_host_wr_arbiter.sv
// Directed vector bench for sgd_host_wr_arbiter (two requesters).
module tb_sgd_host_wr_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_start;
    logic [127:0]  req_addr;
    logic [63:0]   req_length;
    logic [1023:0] req_data;
    logic [1:0]    req_data_valid;
    logic [1:0]    req_almost_full;
    logic [1:0]    req_busy;
    logic          out_start;
    logic [63:0]   out_addr;
    logic [31:0]   out_length;
    logic [511:0]  out_data;
    logic          out_data_valid;
    logic          out_almost_full;
    logic [2:0]    grant_id;
`ifdef SGD_WR_ARB_STATS_EN
    logic [63:0]   stat_xfers;
    logic          stat_err;
`endif

    int n_chk = 0;
    int n_err = 0;

    sgd_host_wr_arbiter #(.NUM_REQ(2), .DATA_W(512), .LEN_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_start(req_start), .req_addr(req_addr), .req_length(req_length),
        .req_data(req_data), .req_data_valid(req_data_valid),
        .req_almost_full(req_almost_full), .req_busy(req_busy),
        .out_start(out_start), .out_addr(out_addr), .out_length(out_length),
        .out_data(out_data), .out_data_valid(out_data_valid),
        .out_almost_full(out_almost_full), .grant_id(grant_id)
`ifdef SGD_WR_ARB_STATS_EN
        , .stat_xfers(stat_xfers), .stat_err(stat_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  start;
        logic [63:0] a0;
        logic [31:0] l0;
        logic [63:0] a1;
        logic [31:0] l1;
        logic [1:0]  dv;
        logic        af;
        logic        ostart;
        logic [63:0] oaddr;
        logic [31:0] olen;
        logic        ovalid;
        logic [1:0]  busy;
        logic [1:0]  rafull;
        logic [2:0]  gid;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic [1:0] start, logic [63:0] a0, logic [31:0] l0,
                                logic [63:0] a1, logic [31:0] l1, logic [1:0] dv, logic af,
                                logic ostart, logic [63:0] oaddr, logic [31:0] olen, logic ovalid,
                                logic [1:0] busy, logic [1:0] rafull, logic [2:0] gid);
        vec_t v;
        v.rst = rst; v.start = start; v.a0 = a0; v.l0 = l0; v.a1 = a1; v.l1 = l1;
        v.dv = dv; v.af = af; v.ostart = ostart; v.oaddr = oaddr; v.olen = olen;
        v.ovalid = ovalid; v.busy = busy; v.rafull = rafull; v.gid = gid;
        return v;
    endfunction

    function automatic logic [511:0] word(int r, int s);
        logic [31:0] w;
        w = (32'(r) << 28) | 32'(s);
        return {16{w}};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] start, input logic [63:0] a0,
                         input logic [31:0] l0, input logic [63:0] a1, input logic [31:0] l1,
                         input logic [1:0] dv, input logic af, input int s);
        rst_n           = rst;
        req_start       = start;
        req_addr        = {a1, a0};
        req_length      = {l1, l0};
        req_data        = {word(1, s), word(0, s)};
        req_data_valid  = dv;
        out_almost_full = af;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int starts;
        int beats;

        // Single request, contention/round robin, zero and short lengths, duplicate starts.
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0));
        vq.push_back(mk(1, 2'b01, 64'h1234, 256, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b11, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 64'h1234, 256, 0, 2'b01, 2'b11, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b10, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b10, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b10, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b11, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0));
        vq.push_back(mk(1, 2'b11, 64'hA000, 128, 64'hB000, 128, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 64'hA000, 128, 0, 2'b11, 2'b11, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b10, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b10, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 1, 2'b10, 2'b11, 0));
        vq.push_back(mk(1, 2'b01, 64'hA040, 128, 0, 0, 2'b10, 0, 1, 64'hB000, 128, 0, 2'b11, 2'b11, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b01, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0, 1, 2'b11, 2'b11, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 2'b11, 2'b01, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 1, 2'b01, 2'b11, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 64'hA040, 128, 0, 2'b01, 2'b11, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b10, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b11, 0));
        vq.push_back(mk(1, 2'b01, 64'h5000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0));
        vq.push_back(mk(1, 2'b10, 0, 0, 64'hC000, 100, 2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b11, 0));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 64'hC000, 100, 0, 2'b10, 2'b11, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b01, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 1, 2'b00, 2'b11, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1));
        vq.push_back(mk(1, 2'b10, 0, 0, 64'hD000, 64, 2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b11, 1));
        vq.push_back(mk(1, 2'b10, 0, 0, 64'hDEAD, 64, 2'b00, 0, 1, 64'hD000, 64, 0, 2'b10, 2'b11, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b01, 1));
        vq.push_back(mk(1, 2'b10, 0, 0, 64'hE000, 64, 2'b10, 0, 0, 0, 0, 1, 2'b00, 2'b11, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1));

        drive(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        tick();
        tick();

        foreach (vq[k]) begin
            vec_t v;
            v = vq[k];
            drive(v.rst, v.start, v.a0, v.l0, v.a1, v.l1, v.dv, v.af, k);
            tick();
            chk($sformatf("v%0d out_start", k), 512'(out_start), 512'(v.ostart));
            chk($sformatf("v%0d out_addr", k), 512'(out_addr), 512'(v.oaddr));
            chk($sformatf("v%0d out_length", k), 512'(out_length), 512'(v.olen));
            chk($sformatf("v%0d out_data_valid", k), 512'(out_data_valid), 512'(v.ovalid));
            chk($sformatf("v%0d req_busy", k), 512'(req_busy), 512'(v.busy));
            chk($sformatf("v%0d req_almost_full", k), 512'(req_almost_full), 512'(v.rafull));
            chk($sformatf("v%0d grant_id", k), 512'(grant_id), 512'(v.gid));
            if (v.ovalid) begin
                chk($sformatf("v%0d out_data", k), out_data, word(int'(v.gid), k));
            end
        end

`ifdef SGD_WR_ARB_STATS_EN
        chk("stat_err sticky", 512'(stat_err), 512'(1));
        chk("stat_xfers req0", 512'(stat_xfers[31:0]), 512'(2));
        chk("stat_xfers req1", 512'(stat_xfers[63:32]), 512'(3));
`endif

        // Back-pressure with a 10-cycle producer pause; valid held otherwise, exactly 4 beats.
        drive(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        tick();
        starts = 0;
        beats  = 0;
        for (int s = 0; s < 40; s++) begin
            logic paused;
            paused = (s >= 5 && s <= 14);
            drive(1, (s == 0) ? 2'b01 : 2'b00, 64'h2000, 256, 0, 0, {1'b0, !paused}, paused, s);
            tick();
            if (out_start) starts++;
            if (out_data_valid) beats++;
            if (s == 3) chk("bp afull low", 512'(req_almost_full[0]), 512'(0));
            if (s == 10) begin
                chk("bp afull high", 512'(req_almost_full[0]), 512'(1));
                chk("bp busy in pause", 512'(req_busy[0]), 512'(1));
            end
        end
        chk("bp commands", 512'(starts), 512'(1));
        chk("bp beats", 512'(beats), 512'(4));
        chk("bp busy end", 512'(req_busy), 512'(0));

        // Reset after 2 of 4 beats, then a fresh 64-byte transfer.
        for (int s = 0; s < 5; s++) begin
            drive(1, (s == 0) ? 2'b01 : 2'b00, 64'h3000, 256, 0, 0, 2'b01, 0, s);
            tick();
        end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b01, 0, 5);
        tick();
        chk("rst out_data_valid", 512'(out_data_valid), 512'(0));
        chk("rst out_data", out_data, 512'(0));
        chk("rst out_start", 512'(out_start), 512'(0));
        chk("rst req_busy", 512'(req_busy), 512'(0));
        chk("rst req_almost_full", 512'(req_almost_full), 512'(2'b11));
        chk("rst grant_id", 512'(grant_id), 512'(0));
        beats = 0;
        for (int s = 0; s < 3; s++) begin
            drive(1, 2'b00, 0, 0, 0, 0, 2'b01, 0, s);
            tick();
            if (out_data_valid) beats++;
        end
        chk("rst no stray beats", 512'(beats), 512'(0));
        starts = 0;
        beats  = 0;
        for (int s = 0; s < 10; s++) begin
            drive(1, (s == 0) ? 2'b01 : 2'b00, 64'h4000, 64, 0, 0, 2'b01, 0, s);
            tick();
            if (out_start) begin
                starts++;
                chk("post-rst out_addr", 512'(out_addr), 512'(64'h4000));
            end
            if (out_data_valid) beats++;
        end
        chk("post-rst commands", 512'(starts), 512'(1));
        chk("post-rst beats", 512'(beats), 512'(1));
        chk("post-rst busy", 512'(req_busy), 512'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sgd_host_wr_arbiter.md
# sgd_host_wr_arbiter

Shares the single host-memory write channel (command + data + almost_full back-pressure) between `NUM_REQ` write producers, e.g. the x-model writer and the loss/statistics writer. Each producer posts a transfer (address, byte length) with a one-cycle start pulse. The arbiter latches the request, grants whole transfers in round-robin order, issues one command per transfer and forwards exactly the announced number of 512-bit beats. It sits between the SGD write producers and the DMA write interface.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_W`, 512: beat width in bits. One beat is 64 bytes.
- `LEN_W`, 32: byte-length width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_start` in NUM_REQ: per-requester one-cycle transfer-post pulse.
- `req_addr` in NUM_REQ×64: host address, sampled with `req_start`.
- `req_length` in NUM_REQ×LEN_W: byte length, sampled with `req_start`. Must be a multiple of 64.
- `req_data` in NUM_REQ×DATA_W: per-requester data beat.
- `req_data_valid` in NUM_REQ: per-requester beat valid.
- `req_almost_full` out NUM_REQ: per-requester stall indication.
- `req_busy` out NUM_REQ: high while a request is pending or granted.
- `out_start` out 1: command pulse.
- `out_addr` out 64: command address.
- `out_length` out LEN_W: command byte length.
- `out_data` out DATA_W: forwarded beat.
- `out_data_valid` out 1: forwarded beat valid.
- `out_almost_full` in 1: downstream back-pressure.
- `grant_id` out 3: index of the current or last granted requester.

## Operation
- Pending latch, per requester:
  - `req_start` with `req_length` != 0 sets `pending[i]` and captures addr/length.
  - `req_start` while `pending[i]` or granted is ignored; the first request wins.
  - `req_start` with length 0 is dropped: no pending bit, no command.
- `req_busy[i]` = `pending[i]` | (granted == i, state != IDLE).
- States:
  - IDLE: if any pending, select a winner round-robin, starting the search at `last+1` mod NUM_REQ. Latch `grant`, load `beats_left` = length>>6, clear that pending bit, go to CMD.
  - CMD: exactly one cycle. Drive `out_start`=1, `out_addr`, `out_length` from the latch. Go to DATA.
  - DATA: a beat is accepted when `req_data_valid[grant]` is high. Each accepted beat decrements `beats_left`. The beat that takes `beats_left` from 1 to 0 returns the FSM to IDLE and sets `last`=grant.
- Back-pressure:
  - `req_almost_full[grant]` = `out_almost_full` while in DATA.
  - All other `req_almost_full` bits are 1. The granted bit is also 1 in IDLE and CMD.
- Valids from non-granted requesters are ignored. Their data is not forwarded.
- Arithmetic: `beats_left` is LEN_W-6 bits wide. Low 6 length bits are truncated, so length 100 gives 1 beat.

## Timing
- Reset values:
  - All `out_*` = 0.
  - `req_almost_full` = all 1s.
  - `req_busy` = 0, `grant_id` = 0.
  - `pending` = 0, state = IDLE.
  - `last` = NUM_REQ-1, so requester 0 has first priority.
- Request path: `req_start` at cycle t → pending at t+1 → IDLE arbitration at t+1 → `out_start` at t+2 (best case, arbiter idle).
- Data path: registered. `out_data`/`out_data_valid` equal the granted input delayed 1 cycle. Downstream must tolerate 1 beat after asserting almost_full.
- Turnaround: last beat accepted at cycle d → IDLE at d+1 → next `out_start` no earlier than d+2. The last beat therefore always leaves the output register before the next command.
- Simultaneous `req_start[i]` on the cycle requester i's transfer completes: ignored. It is counted as posted while granted.
- Reset mid-transfer: at the next clock edge everything returns to reset values. The partial transfer is abandoned, no further beats are forwarded, and pending requests are lost.

## Configuration
- `SGD_WR_ARB_STATS_EN` defined adds the following outputs:
  - `stat_xfers` (NUM_REQ×32): completed transfers per requester, wrapping counters.
  - `stat_err` (1): sticky, set by a non-granted `req_data_valid` or an ignored `req_start`. Cleared only by reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Single requester: req0 start, addr 0x1234, length 256 → one `out_start` with 0x1234/256 at t+2, exactly 4 forwarded beats, FSM back to IDLE.
- Contention: req0 and req1 start in the same cycle, 128 bytes each → req0 served first, then req1. A third round with both pending → req0 again, because `last`=1.
- Back-pressure: `out_almost_full` high mid-transfer → `req_almost_full[grant]`=1. Beat count stays exact when the producer pauses valid for 10 cycles.
- Edge lengths: length 0 → no command and `req_busy` stays 0. Length 100 → 1 beat.
- Duplicate start: req1 start again while pending → single command. With `SGD_WR_ARB_STATS_EN`, `stat_err`=1.
- Reset after 2 of 4 beats → outputs zero next cycle. A new 64-byte request afterwards completes normally.
